// File: rtl/prog_rom_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : prog_rom_line_cache
// Purpose  : Direct-mapped read-only line cache in front of the program-ROM
//            client port; misses fill a whole line with sequential word reads.
// Revision : 1.0 - initial release
// ============================================================================
module prog_rom_line_cache #(
  parameter int ADDR_WIDTH = 23,
  parameter int LINE_LOG2  = 2,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  cpu_cs,
  input  logic                  cpu_oe,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [15:0]           cpu_data,
  output logic                  cpu_data_valid,
  output logic                  rom_cs,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  input  logic                  rom_data_valid
);

  localparam int c_TAG_W   = ADDR_WIDTH - LINE_LOG2 - INDEX_BITS;
  localparam int c_LINES   = 1 << INDEX_BITS;
  localparam int c_WORDS   = 1 << LINE_LOG2;
  localparam int c_LADDR_W = ADDR_WIDTH - LINE_LOG2;
  localparam logic [LINE_LOG2-1:0] c_LAST_WORD = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_GAP  = 2'd2,
    FILL_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_LINES-1:0]   r_valid;
  logic [c_TAG_W-1:0]   r_tag_ram  [c_LINES];
  logic [15:0]          r_data_ram [c_LINES*c_WORDS];
  logic [c_LADDR_W-1:0] r_base;
  logic [LINE_LOG2-1:0] r_k;
  logic                 r_abort;
  logic                 r_hit;
  logic [ADDR_WIDTH-1:0] r_hit_addr;
  logic [15:0]          r_cpu_data;

  logic                  w_req;
  logic [LINE_LOG2-1:0]  w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [c_TAG_W-1:0]    w_tag;
  logic                  w_hit;
  logic                  w_hit_take;
  logic                  w_start;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [c_TAG_W-1:0]    w_fill_tag;
  logic                  w_rom_req;

  assign w_req        = cpu_cs & cpu_oe;
  assign w_word       = cpu_addr[LINE_LOG2-1:0];
  assign w_index      = cpu_addr[LINE_LOG2 +: INDEX_BITS];
  assign w_tag        = cpu_addr[ADDR_WIDTH-1 -: c_TAG_W];
  assign w_hit        = r_valid[w_index] & (r_tag_ram[w_index] == w_tag);
  assign w_hit_take   = (r_state == IDLE) & w_req & w_hit & ~flush;
  assign w_start      = (r_state == IDLE) & w_req & ~w_hit & ~flush;
  assign w_fill_index = r_base[INDEX_BITS-1:0];
  assign w_fill_tag   = r_base[c_LADDR_W-1 -: c_TAG_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rom_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = FILL_REQ;
      end
      FILL_REQ: begin
        w_rom_req = 1'b1;
        // A flushed fill still has to see its outstanding read retire.
        if (rom_data_valid) w_state_nxt = (flush | r_abort) ? IDLE : FILL_GAP;
      end
      FILL_GAP: begin
        if (flush)                   w_state_nxt = IDLE;
        else if (r_k == c_LAST_WORD) w_state_nxt = FILL_DONE;
        else                         w_state_nxt = FILL_REQ;
      end
      FILL_DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_base     <= '0;
      r_k        <= '0;
      r_abort    <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_addr <= '0;
      r_cpu_data <= '0;
    end else begin
      r_hit <= w_hit_take;
      if (w_hit_take) begin
        r_hit_addr <= cpu_addr;
        r_cpu_data <= r_data_ram[{w_index, w_word}];
      end
      if (w_start) begin
        r_base  <= cpu_addr[ADDR_WIDTH-1:LINE_LOG2];
        r_k     <= '0;
        r_abort <= 1'b0;
      end else if ((r_state == FILL_REQ) && flush) begin
        r_abort <= 1'b1;
      end
      if ((r_state == FILL_GAP) && (r_k != c_LAST_WORD)) r_k <= r_k + 1'b1;
      // Invalidate on fill start so a half-refilled line never hits on its old tag.
      if (flush)                       r_valid               <= '0;
      else if (w_start)                r_valid[w_index]      <= 1'b0;
      else if (r_state == FILL_DONE)   r_valid[w_fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == FILL_REQ) && rom_data_valid) r_data_ram[{w_fill_index, r_k}] <= rom_data;
    if (r_state == FILL_DONE)                    r_tag_ram[w_fill_index]          <= w_fill_tag;
  end

  assign rom_cs         = w_rom_req;
  assign rom_oe         = w_rom_req;
  assign rom_addr       = {r_base, r_k};
  assign cpu_data       = r_cpu_data;
  assign cpu_data_valid = r_hit & w_req & (cpu_addr == r_hit_addr);

endmodule
`default_nettype wire

// File: tb/tb_prog_rom_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_rom_line_cache
// Purpose  : Directed self-checking bench with a 3-cycle ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_rom_line_cache;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        cpu_cs = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [15:0] cpu_data;
  logic        cpu_data_valid;
  logic        rom_cs;
  logic        rom_oe;
  logic [22:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_data_valid;

  int n_err = 0;
  int n_chk = 0;

  prog_rom_line_cache dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .cpu_cs         (cpu_cs),
    .cpu_oe         (cpu_oe),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .cpu_data_valid (cpu_data_valid),
    .rom_cs         (rom_cs),
    .rom_oe         (rom_oe),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_data_valid (rom_data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [22:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // ROM answers in the third cycle of a held request.
  logic [2:0] rom_cnt = '0;
  always @(posedge clk) rom_cnt <= (rom_cs && rom_oe) ? rom_cnt + 3'd1 : 3'd0;
  assign rom_data_valid = rom_cs && rom_oe && (rom_cnt == 3'd2);
  assign rom_data       = rom_word(rom_addr);

  logic [22:0] rom_log [64];
  int          rom_n = 0;
  int          rom_rises = 0;
  logic        rom_cs_q = 1'b0;
  always @(posedge clk) begin
    if (rom_cs && rom_data_valid) begin
      rom_log[rom_n[5:0]] <= rom_addr;
      rom_n <= rom_n + 1;
    end
    if (rom_cs && !rom_cs_q) rom_rises <= rom_rises + 1;
    rom_cs_q <= rom_cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency = edges after the one that samples the request until valid shows.
  task automatic do_read(input logic [22:0] a, output int lat);
    @(negedge clk);
    cpu_addr = a; cpu_cs = 1'b1; cpu_oe = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!cpu_data_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, n0, r0, w, hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_oe", 32'(rom_oe), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(cpu_data_valid), 32'd0);
    chk("rst_data", 32'(cpu_data), 32'd0);
    reset_n = 1'b1;

    // Cold miss at 0x10
    n0 = rom_n; r0 = rom_rises;
    do_read(23'h10, lat);
    chk("t1_latency", 32'(lat), 32'd18);
    chk("t1_data", 32'(cpu_data), 32'(rom_word(23'h10)));
    chk("t1_reads", 32'(rom_n - n0), 32'd4);
    chk("t1_cs_rises", 32'(rom_rises - r0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_rom_addr", 32'(rom_log[6'(n0 + i)]), 32'h10 + 32'(i));

    // Sequential hits within the line
    r0 = rom_rises;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      cpu_addr = 23'(32'h10 + i);
      #1 chk("t2_addr_change_drop", 32'(cpu_data_valid), 32'd0);
      @(posedge clk); #1;
      chk("t2_hit_valid", 32'(cpu_data_valid), 32'd1);
      chk("t2_hit_data", 32'(cpu_data), 32'(rom_word(23'(32'h10 + i))));
    end
    chk("t2_no_rom", 32'(rom_rises - r0), 32'd0);

    // Conflict miss at 0x110 evicts 0x10
    @(negedge clk); cpu_cs = 1'b0;
    n0 = rom_n;
    do_read(23'h110, lat);
    chk("t3_latency", 32'(lat), 32'd18);
    chk("t3_data", 32'(cpu_data), 32'(rom_word(23'h110)));
    chk("t3_reads", 32'(rom_n - n0), 32'd4);
    chk("t3_last_addr", 32'(rom_log[6'(n0 + 3)]), 32'h113);
    @(negedge clk); cpu_cs = 1'b0;
    do_read(23'h10, lat);
    chk("t3_reread_miss", 32'(lat), 32'd18);

    // Flush during the word-2 request
    @(negedge clk); cpu_cs = 1'b0;
    n0 = rom_n;
    @(negedge clk); cpu_addr = 23'h2000; cpu_cs = 1'b1; cpu_oe = 1'b1;
    w = 0;
    while (!(rom_cs && rom_addr == 23'h2002) && w < 200) begin
      @(negedge clk); w++;
    end
    chk("t4_reach_word2", 32'(w < 200), 32'd1);
    flush = 1'b1; cpu_cs = 1'b0;
    @(negedge clk); flush = 1'b0;
    w = 0;
    while (rom_n < n0 + 3 && w < 20) begin
      @(negedge clk); w++;
    end
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (rom_cs) hi++;
    end
    chk("t4_reads_done", 32'(rom_n - n0), 32'd3);
    chk("t4_last_addr", 32'(rom_log[6'(n0 + 2)]), 32'h2002);
    chk("t4_cs_idle", 32'(hi), 32'd0);
    n0 = rom_n;
    do_read(23'h2000, lat);
    chk("t4_refill_latency", 32'(lat), 32'd18);
    chk("t4_refill_reads", 32'(rom_n - n0), 32'd4);
    @(negedge clk); cpu_cs = 1'b0;
    do_read(23'h10, lat);
    chk("t4_flushed_line_miss", 32'(lat), 32'd18);

    // Valid drop on deselect and on address change; flush beats a hit
    @(negedge clk); cpu_cs = 1'b0;
    #1 chk("t5_cs_drop", 32'(cpu_data_valid), 32'd0);
    @(negedge clk); cpu_cs = 1'b1; cpu_addr = 23'h11;
    @(posedge clk); #1 chk("t5_hit", 32'(cpu_data_valid), 32'd1);
    @(negedge clk); cpu_addr = 23'h12;
    #1 chk("t5_addr_drop", 32'(cpu_data_valid), 32'd0);
    @(posedge clk); #1 chk("t5_hit2", 32'(cpu_data_valid), 32'd1);
    @(negedge clk); cpu_addr = 23'h13; flush = 1'b1;
    @(posedge clk); #1;
    chk("t5_flush_wins", 32'(cpu_data_valid), 32'd0);
    chk("t5_no_fill_in_flush", 32'(rom_cs), 32'd0);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    chk("t5_miss_after_flush", 32'(rom_cs), 32'd1);
    chk("t5_fill_base", 32'(rom_addr), 32'h10);
    w = 0;
    while (!cpu_data_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("t5_fill_data", 32'(cpu_data), 32'(rom_word(23'h13)));

    // Async reset mid-fill
    @(negedge clk); cpu_addr = 23'h40;
    w = 0;
    while (!(rom_cs && rom_addr == 23'h41) && w < 200) begin
      @(negedge clk); w++;
    end
    chk("t6_reach_word1", 32'(w < 200), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_rom_cs", 32'(rom_cs), 32'd0);
    chk("t6_async_rom_oe", 32'(rom_oe), 32'd0);
    chk("t6_async_valid", 32'(cpu_data_valid), 32'd0);
    @(negedge clk); cpu_cs = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    do_read(23'h40, lat);
    chk("t6_miss_after_reset", 32'(lat), 32'd18);
    chk("t6_data", 32'(cpu_data), 32'(rom_word(23'h40)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
